// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - glyph constants, FSM states and decoded-digit type for the scan decoder
package seg_scan_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       err;
  } digit_t;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - 7-segment {g..a} pattern to 4-bit value; SEG_SCAN_HEX_EN adds A..F glyphs
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    value = 4'd0;
    err   = 1'b0;
    case (seg)
      SEG_0: value = 4'd0;
      SEG_1: value = 4'd1;
      SEG_2: value = 4'd2;
      SEG_3: value = 4'd3;
      SEG_4: value = 4'd4;
      SEG_5: value = 4'd5;
      SEG_6: value = 4'd6;
      SEG_7: value = 4'd7;
      SEG_8: value = 4'd8;
      SEG_9: value = 4'd9;
`ifdef SEG_SCAN_HEX_EN
      SEG_A: value = 4'd10;
      SEG_B: value = 4'd11;
      SEG_C: value = 4'd12;
      SEG_D: value = 4'd13;
      SEG_E: value = 4'd14;
      SEG_F: value = 4'd15;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment bus readback: deghost, decode, assemble frames (SEG_SCAN_HEX_EN: hex glyphs)
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGIT      = 6,
  parameter int SETTLE_CYC     = 4,
  parameter int TIMEOUT_CYC    = 1000000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int ENB_ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             i_seg,
  input  logic [NUM_DIGIT-1:0]   i_seg_enb,
  input  logic                   i_seg_dp,
  output logic [4*NUM_DIGIT-1:0] o_digits,
  output logic [NUM_DIGIT-1:0]   o_dp,
  output logic [NUM_DIGIT-1:0]   o_digit_err,
  output logic                   o_frame_valid,
  output logic                   o_stale
);

  localparam int IW = (NUM_DIGIT > 1) ? $clog2(NUM_DIGIT) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]        TO_MAX     = TW'(TIMEOUT_CYC);
  localparam logic [7:0]           SETTLE_MAX = 8'(SETTLE_CYC);
  localparam logic [NUM_DIGIT-1:0] ALL_ONES   = '1;

  logic [6:0]           seg_q, t_seg;
  logic [NUM_DIGIT-1:0] enb_q, t_enb;
  logic                 dp_q, t_dp;
  logic                 legal, match, latch, accept;
  logic [IW-1:0]        idx;
  logic [7:0]           cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt;
  logic [NUM_DIGIT-1:0] mask;
  digit_t [NUM_DIGIT-1:0] slot;
  logic [3:0]           dec_value;
  logic                 dec_err;
  digit_t               dec_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      enb_q <= '0;
      dp_q  <= 1'b0;
    end else begin
      seg_q <= (SEG_ACTIVE_LOW != 0) ? ~i_seg : i_seg;
      enb_q <= (ENB_ACTIVE_LOW != 0) ? ~i_seg_enb : i_seg_enb;
      dp_q  <= i_seg_dp;
    end
  end

  assign legal = $onehot(enb_q);
  assign match = (enb_q == t_enb) && (seg_q == t_seg) && (dp_q == t_dp);

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_DIGIT; k++) begin
      if (enb_q[k]) idx = IW'(k);
    end
  end

  seg7_to_hex u_dec (
    .seg   (seg_q),
    .value (dec_value),
    .err   (dec_err)
  );

  assign dec_digit = '{value: dec_value, dp: dp_q, err: dec_err};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_seg   <= '0;
      t_enb   <= '0;
      t_dp    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        t_seg <= seg_q;
        t_enb <= enb_q;
        t_dp  <= dp_q;
      end
    end
  end

  // A fresh tuple counts as its first sample, so SETTLE_CYC=1 accepts on sight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          latch = 1'b1;
          cnt_d = 8'd1;
          if (SETTLE_MAX <= 8'd1) begin
            accept  = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!legal) begin
          state_d = IDLE;
        end else if (!match) begin
          latch = 1'b1;
          cnt_d = 8'd1;
          if (SETTLE_MAX <= 8'd1) begin
            accept  = 1'b1;
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d >= SETTLE_MAX) begin
            accept  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept beats timeout expiry; a completed frame beats both for mask and stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt          <= '0;
      mask          <= '0;
      slot          <= '0;
      o_digits      <= '0;
      o_dp          <= '0;
      o_digit_err   <= '0;
      o_frame_valid <= 1'b0;
      o_stale       <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      if (accept)
        tcnt <= '0;
      else if (tcnt < TO_MAX)
        tcnt <= tcnt + TW'(1);

      if (accept) slot[idx] <= dec_digit;

      if (mask == ALL_ONES) begin
        for (int k = 0; k < NUM_DIGIT; k++) begin
          o_digits[4*k +: 4] <= slot[k].value;
          o_dp[k]            <= slot[k].dp;
          o_digit_err[k]     <= slot[k].err;
        end
        o_frame_valid <= 1'b1;
        o_stale       <= 1'b0;
        mask          <= '0;
        if (accept) mask[idx] <= 1'b1;
      end else if (accept) begin
        mask[idx] <= 1'b1;
      end else if (tcnt == TO_MAX) begin
        o_stale <= 1'b1;
        mask    <= '0;
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 6-digit 7-segment display driver.
- Samples the scanned segment, digit-enable and decimal-point lines, and filters scan-transition ghosting.
- Decodes each digit pattern back to a 4-bit value and assembles a complete 6-digit frame.
- Used as an on-chip self-check and readback monitor on the display bus, driven by the same clock as the display driver.

Parameters:
- NUM_DIGIT, 6: number of scanned digits (enable width).
- SETTLE_CYC, 4: consecutive identical samples needed before a digit is accepted (1..255).
- TIMEOUT_CYC, 1000000: cycles without any accepted digit before the frame is declared stale.
- SEG_ACTIVE_LOW, 0: 1 = segment lines are active-low; inverted before decode.
- ENB_ACTIVE_LOW, 0: 1 = digit enables are active-low; inverted before use.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- i_seg  input  7  segment lines {g,f,e,d,c,b,a}.
- i_seg_enb  input  NUM_DIGIT  digit enables; bit k selects digit k.
- i_seg_dp  input  1  decimal point of the enabled digit.
- o_digits  output  4*NUM_DIGIT  decoded frame; digit k at [4k+3:4k].
- o_dp  output  NUM_DIGIT  decimal-point bit per digit.
- o_digit_err  output  NUM_DIGIT  1 = digit pattern was not a legal glyph.
- o_frame_valid  output  1  one-cycle pulse when o_digits/o_dp/o_digit_err update.
- o_stale  output  1  1 = no digit accepted for TIMEOUT_CYC cycles.

Behaviour:
- Clocking and reset: all logic on the rising edge of clk. While rst=1, every output is 0, the capture mask and all counters are 0, and the FSM is in IDLE.
- Input stage: i_seg, i_seg_enb and i_seg_dp are registered once, with polarity normalised per the parameters. All decisions use the registered copy (1-cycle input latency).
- Legal enable: exactly one bit set. Zero or multiple bits set means blanking.
- FSM states:
  - IDLE: waiting for a legal enable. On a legal enable, latch the {enable, seg, dp} tuple, set settle count to 1, go to SETTLE.
  - SETTLE: each cycle the tuple matches, increment the count. When count reaches SETTLE_CYC, accept the digit and go to HOLD. On a tuple mismatch with a legal enable, restart the count at 1 with the new tuple. On blanking, go to IDLE.
  - HOLD: the digit has been accepted and is not re-accepted while the tuple is unchanged. Any tuple change goes to IDLE, then to SETTLE on the next legal enable.
- Accept action:
  - Decode seg into slot k (k = index of the enable bit): value, dp and err.
  - Set mask[k]=1. If slot k was already set, the new value overwrites it.
  - Clear the timeout counter.
- Frame completion:
  - The cycle after an accept that makes the mask all ones, o_digits, o_dp and o_digit_err load from the slots and o_frame_valid=1 for exactly one cycle.
  - The mask clears in the same cycle, and o_stale clears.
- Between frames, the outputs hold their last values.
- Decode table (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other pattern, including blank 00, gives value 0 and err=1.
- Timeout:
  - The counter increments every cycle it is below TIMEOUT_CYC and saturates there.
  - On reaching TIMEOUT_CYC: o_stale=1 and the mask is cleared, so partial frames are discarded. Captured slots are not output.
- Simultaneous events: if accept and timeout expiry coincide, accept wins (the counter clears, o_stale is not set). The 6th accept followed by immediate blanking still produces o_frame_valid.
- Reset mid-frame: the partial frame is lost and the next frame starts from an empty mask.

Optional Feature:
- Macro SEG_SCAN_HEX_EN.
- Defined: the decode table adds A=77, b=7C, C=39, d=5E, E=79, F=71, giving values 10..15 with err=0.
- Undefined: those six patterns decode as value 0 with err=1.

Decomposition:
- Package seg_scan_pkg holds:
  - the 7-bit glyph constants (SEG_0..SEG_9, SEG_A..SEG_F);
  - the FSM state typedef (IDLE, SETTLE, HOLD);
  - a decoded-digit struct {value[3:0], dp, err}.
- One combinational sub-module, seg7_to_hex: 7-bit pattern in, value and err out. The SEG_SCAN_HEX_EN switch lives there.
- The top block keeps the FSM, settle counter, mask, slots and timeout.

Test Plan (SETTLE_CYC=4, TIMEOUT_CYC=100, active-high lines):
- Clean frame: scan digits 0..5 with patterns for 1,2,3,4,5,6, 8 cycles each, dp on digit 2 only -> o_frame_valid single pulse; o_digits=24'h654321; o_dp=6'b000100; o_digit_err=0.
- Ghosting: digit 0 shows 3F for 3 cycles then 06 for 8 cycles -> slot 0 = 1, never 0. A 2-hot enable (6'b000011) for 10 cycles -> no accept.
- Illegal glyph: digit 3 = 7F changed to 00, 8 cycles, rest legal -> o_digit_err=6'b001000 and o_digits[15:12]=0. Glyph 77 -> err set without macro, value A with err=0 when SEG_SCAN_HEX_EN is defined.
- Timeout: capture digits 0..2, then hold enables at 0 for 100 cycles -> o_stale=1, no frame pulse, previous o_digits unchanged. A following full frame -> pulse and o_stale=0.
- Overwrite and reset: scan digit 1 as 7, then 9, before completing the frame -> frame shows 9 in slot 1. Assert rst for 1 cycle mid-frame -> all outputs 0; the next full frame is reported correctly.
- Long hold: digit 4 held stable for 1000 cycles -> accepted once only; its held, unchanged tuple alone causes no frame pulse.
